// File: rtl/base_sys_mem_test_pkg.sv
// base_sys_mem_test_pkg: shared state encoding, byte-enable constant and default widths for the memory test master
package base_sys_mem_test_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF = 14;
  localparam int ERR_W_DEF = 16;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;
  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} state_t;
endpackage

// File: rtl/base_sys_mem_test_master.sv
// base_sys_mem_test_master: Avalon-MM write/readback/compare self-test engine for the system memory
// Ports: clk, reset_n (async, active low); control start/abort; test setup base_addr/word_count/seed;
// status busy/done/pass/aborted/err_count/first_err_addr; Avalon-MM master avm_* (32-bit, one read outstanding).
module base_sys_mem_test_master
  import base_sys_mem_test_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);
  state_t state, state_d;
  logic [ADDR_W-1:0] base_q, addr;
  logic [CNT_W-1:0] idx, cnt_q;
  logic [31:0] seed_q, pattern;
  logic fin, last, go, wr_acc, rd_acc, rdv_ok, mismatch;
  assign pattern = seed_q + 32'(idx);
  assign addr = base_q + ADDR_W'({idx, 2'b00});
  assign last = idx == cnt_q - 1'b1;
  assign go = state == IDLE && start;
  assign wr_acc = state == WRITE && !avm_waitrequest;
  assign rd_acc = state == READ_REQ && !avm_waitrequest;
  assign rdv_ok = state == READ_WAIT && avm_readdatavalid;
  assign mismatch = avm_readdata != pattern;
  assign avm_write = state == WRITE;
  assign avm_read = state == READ_REQ;
  assign avm_address = addr;
  assign avm_writedata = pattern;
  assign avm_byteenable = BYTEEN_ALL;
  assign busy = avm_write || avm_read || state == READ_WAIT;
  assign done = state == DONE;
  // fin marks a finished test so pass stays valid until the next start
  assign pass = fin && err_count == '0 && !aborted;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start) state_d = word_count != '0 ? WRITE : DONE;
      WRITE:     if (!avm_waitrequest) state_d = abort ? DONE : last ? READ_REQ : WRITE;
      READ_REQ:  if (!avm_waitrequest) state_d = abort ? DONE : READ_WAIT;
      READ_WAIT: if (avm_readdatavalid) state_d = abort || last ? DONE : READ_REQ;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      seed_q <= '0;
      idx <= '0;
      err_count <= '0;
      first_err_addr <= '0;
      aborted <= 1'b0;
      fin <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        base_q <= {base_addr[ADDR_W-1:2], 2'b00};
        cnt_q <= word_count;
        seed_q <= seed;
        idx <= '0;
        err_count <= '0;
        first_err_addr <= '0;
        aborted <= 1'b0;
      end
      if (wr_acc) idx <= last ? '0 : idx + 1'b1;
      if (rdv_ok) begin
        idx <= idx + 1'b1;
        if (mismatch && !(&err_count)) err_count <= err_count + 1'b1;
        if (mismatch && err_count == '0) first_err_addr <= addr;
      end
      // abort is only honoured at transfer boundaries, never mid-handshake
      if ((wr_acc || rd_acc || rdv_ok) && abort) aborted <= 1'b1;
      fin <= state_d == DONE ? 1'b1 : go ? 1'b0 : fin;
    end
  end
endmodule

// File: tb/tb_base_sys_mem_test_master.sv
// tb_base_sys_mem_test_master: scoreboard bench with a latency-1 memory slave model for the test master
module tb_base_sys_mem_test_master;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [15:0] base_addr = 0;
  logic [13:0] word_count = 0;
  logic [31:0] seed = 0;
  logic busy, done, pass, aborted, avm_read, avm_write, avm_waitrequest;
  logic [15:0] err_count, first_err_addr, avm_address;
  logic [3:0] avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata = 0;
  logic avm_readdatavalid = 0;
  int checks = 0, errors = 0, cyc;
  typedef struct {logic [15:0] err; logic [15:0] first; logic ab; logic ps;} res_t;
  logic [47:0] wq[$];
  logic [15:0] rq[$];
  res_t resq[$];
  logic [31:0] mem[0:16383];
  int stall_n = 0, scnt = 0;
  logic corrupt_en = 0;
  logic [15:0] corrupt_addr = 0;
  always #5 clk = ~clk;
  base_sys_mem_test_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .aborted(aborted), .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  assign avm_waitrequest = (avm_read || avm_write) && scnt < stall_n;
  always @(posedge clk) begin
    scnt <= ((avm_read || avm_write) && avm_waitrequest) ? scnt + 1 : 0;
    if (avm_write && !avm_waitrequest) mem[avm_address[15:2]] <= avm_writedata;
    avm_readdatavalid <= avm_read && !avm_waitrequest;
    avm_readdata <= mem[avm_address[15:2]] ^ ((corrupt_en && avm_address == corrupt_addr) ? 32'h1 : 32'h0);
  end
  logic stalled = 0;
  logic [15:0] s_addr;
  logic [31:0] s_data;
  always @(negedge clk) begin
    logic [47:0] e;
    res_t r;
    if (stalled && (avm_read || avm_write)) begin
      chk("stall_addr", avm_address, s_addr);
      chk("stall_data", avm_writedata, s_data);
    end
    stalled = (avm_read || avm_write) && avm_waitrequest;
    s_addr = avm_address;
    s_data = avm_writedata;
    if (avm_write && !avm_waitrequest) begin
      if (wq.size() == 0) chk("extra_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", avm_address, e[47:32]);
        chk("wr_data", avm_writedata, e[31:0]);
      end
    end
    if (avm_read && !avm_waitrequest) begin
      if (rq.size() == 0) chk("extra_read", 1, 0);
      else chk("rd_addr", avm_address, rq.pop_front());
    end
    if (done) begin
      if (resq.size() == 0) chk("extra_done", 1, 0);
      else begin
        r = resq.pop_front();
        chk("err_count", err_count, r.err);
        chk("first_err_addr", first_err_addr, r.first);
        chk("aborted", aborted, r.ab);
        chk("pass", pass, r.ps);
      end
    end
  end
  task automatic start_test(input logic [15:0] b, input logic [13:0] n, input logic [31:0] s,
                            input int nw, input int nr, input logic [15:0] e_err,
                            input logic [15:0] e_first, input logic e_ab, input logic e_ps);
    logic [15:0] bb;
    bb = {b[15:2], 2'b00};
    for (int i = 0; i < nw; i++) wq.push_back({16'(bb + 16'(4 * i)), s + 32'(i)});
    for (int i = 0; i < nr; i++) rq.push_back(16'(bb + 16'(4 * i)));
    resq.push_back('{e_err, e_first, e_ab, e_ps});
    base_addr = b;
    word_count = n;
    seed = s;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  task automatic queues_empty(input string tag);
    chk({tag, "_wq"}, wq.size(), 0);
    chk({tag, "_rq"}, rq.size(), 0);
    chk({tag, "_res"}, resq.size(), 0);
  endtask
  task automatic reset_outputs(input string tag);
    chk({tag, "_status"}, {busy, done, pass, aborted, err_count, first_err_addr}, 0);
    chk({tag, "_cmd"}, {avm_read, avm_write, avm_address, avm_writedata}, 0);
    chk({tag, "_be"}, avm_byteenable, 4'hF);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    reset_n = 1;
    @(negedge clk);
    start_test(16'h0100, 4, 32'hA5A5_0000, 4, 4, 0, 0, 0, 1);
    chk("busy_t1", busy, 1);
    wait_done(cyc);
    chk("lat_t1", cyc, 13);
    queues_empty("t1");
    corrupt_en = 1;
    corrupt_addr = 16'h0108;
    start_test(16'h0100, 4, 32'hA5A5_0000, 4, 4, 1, 16'h0108, 0, 0);
    wait_done(cyc);
    chk("lat_t2", cyc, 13);
    chk("pass_hold_t2", pass, 0);
    queues_empty("t2");
    corrupt_en = 0;
    stall_n = 3;
    start_test(16'h0100, 4, 32'hA5A5_0000, 4, 4, 0, 0, 0, 1);
    wait_done(cyc);
    chk("pass_hold_t3", pass, 1);
    queues_empty("t3");
    stall_n = 0;
    start_test(16'h0100, 0, 32'h1, 0, 0, 0, 0, 0, 1);
    chk("busy_t4", busy, 0);
    wait_done(cyc);
    chk("lat_t4", cyc, 1);
    queues_empty("t4");
    stall_n = 3;
    start_test(16'h0100, 4, 32'hDEAD_0000, 1, 0, 0, 0, 1, 0);
    abort = 1;
    wait_done(cyc);
    abort = 0;
    repeat (3) @(negedge clk);
    queues_empty("t5");
    stall_n = 0;
    start_test(16'hFFF8, 3, 32'hFFFF_FFFF, 3, 3, 0, 0, 0, 1);
    wait_done(cyc);
    chk("lat_t5b", cyc, 10);
    queues_empty("t5b");
    start_test(16'h0101, 4, 32'h0BAD_F00D, 4, 4, 0, 0, 0, 1);
    cyc = 0;
    while (!(avm_read && !avm_waitrequest) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("read_seen", avm_read, 1);
    @(negedge clk);
    reset_n = 0;
    #1;
    reset_outputs("midreset");
    wq.delete();
    rq.delete();
    resq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_rst", done, 0);
    end
    reset_n = 1;
    @(negedge clk);
    start_test(16'h0200, 2, 32'h1234_5678, 2, 2, 0, 0, 0, 1);
    wait_done(cyc);
    chk("lat_t6", cyc, 7);
    queues_empty("t6");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
